// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings and op-class decode helpers for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_ACC  = 2'd3
    } mdu_state_e;

    // Arithmetic ops occupy codes 0..7; bit 0 set marks the unsigned variant.
    function automatic logic is_arith(input logic [3:0] op);
        return op[3] == 1'b0;
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return is_arith(op) && !op[0];
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op[3:1] == 3'b001;
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return op[3:1] == 3'b011;
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: combinational conditional two's complement (o_y = i_sel ? -i_x : i_x)
//   i_sel  in  1      negate when set
//   i_x    in  WIDTH  value
//   o_y    out WIDTH  result
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? ~i_x + 1'b1 : i_x;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential shift-add multiply / restoring divide unit with HI/LO, MADD/MSUB and abort
//   i_clk, i_arst_n      clock, asynchronous active-low reset
//   i_start, i_op        request and op code (accepted only when idle)
//   i_data_a, i_data_b   rs / rt operands
//   i_abort              cancel the operation in flight
//   o_busy               operation in flight
//   o_done               one-cycle pulse after HI/LO update by an arithmetic op
//   o_div_zero           one-cycle pulse after a rejected divide by zero
//   o_hi, o_lo           architectural HI/LO registers
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_start,
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_zero,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W - 1);

    mdu_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    // ph/pl: shadow product {hi,lo} for multiply, {remainder,quotient} for divide
    logic [W-1:0]         ph_q, ph_d, pl_q, pl_d;
    // mag: multiplicand or divisor magnitude
    logic [W-1:0]         mag_q, mag_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic                 div_q, div_d, acc_q, acc_d, sub_q, sub_d;
    logic                 done_q, done_d, dz_q, dz_d;

    logic [W-1:0]   abs_a, abs_b, quo_fix, rem_fix, dshift;
    logic [2*W-1:0] prod_fix, fix_res, acc_res;
    logic [W:0]     msum, dsub;
    logic           borrow, neg_a, neg_b;

    assign neg_a = is_signed(i_op) && i_data_a[W-1];
    assign neg_b = is_signed(i_op) && i_data_b[W-1];

    mdu_negate #(.WIDTH(W)) u_neg_a (.i_sel(neg_a), .i_x(i_data_a), .o_y(abs_a));
    mdu_negate #(.WIDTH(W)) u_neg_b (.i_sel(neg_b), .i_x(i_data_b), .o_y(abs_b));

    mdu_negate #(.WIDTH(2*W)) u_neg_p (.i_sel(sa_q ^ sb_q), .i_x({ph_q, pl_q}), .o_y(prod_fix));
    mdu_negate #(.WIDTH(W))   u_neg_q (.i_sel(sa_q ^ sb_q), .i_x(pl_q), .o_y(quo_fix));
    mdu_negate #(.WIDTH(W))   u_neg_r (.i_sel(sa_q), .i_x(ph_q), .o_y(rem_fix));

    assign fix_res = div_q ? {rem_fix, quo_fix} : prod_fix;
    assign acc_res = sub_q ? {hi_q, lo_q} - {ph_q, pl_q} : {hi_q, lo_q} + {ph_q, pl_q};

    assign msum = {1'b0, ph_q} + (pl_q[0] ? {1'b0, mag_q} : {(W+1){1'b0}});

    // Shifted partial remainder is W+1 bits; when its top bit (ph_q[W-1]) is set it
    // already exceeds any divisor, so only the low W bits need the trial subtract.
    assign dshift = {ph_q[W-2:0], pl_q[W-1]};
    assign dsub   = {1'b0, dshift} - {1'b0, mag_q};
    assign borrow = !ph_q[W-1] && dsub[W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        mag_d   = mag_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        acc_d   = acc_q;
        sub_d   = sub_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_start && !i_abort) begin
                if (i_op == OP_MTHI) begin
                    hi_d = i_data_a;
                end else if (i_op == OP_MTLO) begin
                    lo_d = i_data_a;
                end else if (is_div(i_op) && i_data_b == '0) begin
                    dz_d = 1'b1;
                end else if (is_arith(i_op)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    ph_d    = '0;
                    pl_d    = is_div(i_op) ? abs_a : abs_b;
                    mag_d   = is_div(i_op) ? abs_b : abs_a;
                    sa_d    = neg_a;
                    sb_d    = neg_b;
                    div_d   = is_div(i_op);
                    acc_d   = is_acc(i_op);
                    sub_d   = is_sub(i_op);
                end
            end
        end else if (i_abort) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                ph_d = borrow ? dshift : dsub[W-1:0];
                pl_d = {pl_q[W-2:0], ~borrow};
            end else begin
                {ph_d, pl_d} = {msum, pl_q[W-1:1]};
            end
            state_d = (cnt_q == LAST) ? ST_FIX : ST_RUN;
        end else if (state_q == ST_FIX) begin
            if (acc_q) begin
                {ph_d, pl_d} = fix_res;
                state_d      = ST_ACC;
            end else begin
                {hi_d, lo_d} = fix_res;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
        end else begin
            {hi_d, lo_d} = acc_res;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            mag_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            mag_q   <= mag_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign o_busy     = state_q != ST_IDLE;
    assign o_done     = done_q;
    assign o_div_zero = dz_q;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and randomized self-checking bench for mdu_seq against a behavioural model
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0, abort = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    logic       s8 = 1'b0;
    logic [3:0] op8 = 4'd0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] hi8, lo8;

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    mdu_seq #(.DATA_WIDTH(W)) u_dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_start(start), .i_op(op),
        .i_data_a(a), .i_data_b(b), .i_abort(abort),
        .o_busy(busy), .o_done(done), .o_div_zero(dz), .o_hi(hi), .o_lo(lo)
    );

    mdu_seq #(.DATA_WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_arst_n(rst_n), .i_start(s8), .i_op(op8),
        .i_data_a(a8), .i_data_b(b8), .i_abort(1'b0),
        .o_busy(busy8), .o_done(done8), .o_div_zero(dz8), .o_hi(hi8), .o_lo(lo8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result of an arithmetic op as {HI,LO}, using plain 64-bit arithmetic.
    function automatic logic [63:0] compute(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] hl);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        logic [63:0] ux = {32'd0, x};
        logic [63:0] uy = {32'd0, y};
        longint q, r;
        logic [63:0] uq, ur;
        case (o)
            4'd0: return sx * sy;
            4'd1: return ux * uy;
            4'd2: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
            4'd3: begin uq = ux / uy; ur = ux % uy; return {ur[31:0], uq[31:0]}; end
            4'd4: return hl + sx * sy;
            4'd5: return hl + ux * uy;
            4'd6: return hl - sx * sy;
            default: return hl - ux * uy;
        endcase
    endfunction

    // Behavioural model: HI/LO, cycles remaining until the result lands, pending result.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_rem;
    logic        m_done, m_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_res = 0; m_rem = 0; m_done = 0; m_dz = 0;
        end else begin
            m_done = 0;
            m_dz = 0;
            if (m_rem > 0) begin
                if (abort) m_rem = 0;
                else begin
                    m_rem--;
                    if (m_rem == 0) begin {m_hi, m_lo} = m_res; m_done = 1; end
                end
            end else if (start && !abort) begin
                if (op == 4'd8) m_hi = a;
                else if (op == 4'd9) m_lo = a;
                else if (op <= 4'd7) begin
                    if ((op == 4'd2 || op == 4'd3) && b == 0) m_dz = 1;
                    else begin
                        m_res = compute(op, a, b, {m_hi, m_lo});
                        m_rem = (op >= 4'd4) ? W + 2 : W + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_rem > 0);
            chk("done", done, m_done);
            chk("div_zero", dz, m_dz);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string name, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int lat, input logic [31:0] ehi,
                       input logic [31:0] elo);
        int n = 0;
        issue(o, x, y);
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk({name, " latency"}, n, lat);
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
    endtask

    task automatic run8(input string name, input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] ehi, input logic [7:0] elo);
        int n = 0;
        @(negedge clk);
        s8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(negedge clk);
        s8 = 1'b0;
        while (!done8 && n < 100) begin @(negedge clk); n++; end
        chk({name, " latency"}, n, 9);
        chk({name, " hi"}, hi8, ehi);
        chk({name, " lo"}, lo8, elo);
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, ndone;
        repeat (3) @(negedge clk);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset div_zero", dz, 0);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        run("mult", OP_MULT, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("multu", OP_MULTU, 32'd7, 32'hFFFF_FFFD, 33, 32'h0000_0006, 32'hFFFF_FFEB);
        run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 33, 32'h0000_0001, 32'h7FFF_FFFC);
        run("div min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'd5, 32'd0);
        chk("mtlo lo", lo, 32'd5);
        chk("mthi hi", hi, 32'd0);
        run("madd", OP_MADD, 32'd3, 32'd4, 34, 32'h0, 32'h11);
        run("msubu", OP_MSUBU, 32'd1, 32'h12, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        issue(OP_DIVU, 32'd9, 32'd0);
        chk("dz pulse", dz, 1);
        chk("dz busy", busy, 0);
        chk("dz hi", hi, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("dz pulse end", dz, 0);
        run("divu 9/4", OP_DIVU, 32'd9, 32'd4, 33, 32'd1, 32'd2);

        issue(OP_MULT, 32'd5, 32'd5);
        repeat (7) @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort hi", hi, 32'd1);
        chk("abort lo", lo, 32'd2);
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        chk("abort no done", ndone, 0);

        run8("mult8", OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
        run8("div8 min", OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80);

        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd9;
        s8 = 1'b1; op8 = OP_MULTU; a8 = 8'd7; b8 = 8'd7;
        @(negedge clk);
        start = 1'b0; s8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset hi", hi, 0);
        chk("mid reset lo", lo, 0);
        chk("mid reset busy8", busy8, 0);
        chk("mid reset hi8", hi8, 0);
        chk("mid reset lo8", lo8, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            start = 1'b1;
            op = 4'($urandom_range(0, 15));
            a = rnd();
            b = rnd();
            abort = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            n = 0;
            while (busy && n < 100) begin
                start = ($urandom_range(0, 7) == 0);
                op = 4'($urandom_range(0, 15));
                a = $urandom;
                abort = ($urandom_range(0, 40) == 0);
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            abort = 1'b0;
            chk("random timeout", n < 100, 1);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
